// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB first, through a registered carry.
// Operands are accepted on start in IDLE or DONE; done pulses for one cycle with result and flags.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] sh_shift;
  logic             c_into_msb;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (k_q == K_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // One digit of ripple add; the sum digit enters the result shift register at the MSB end
  assign dsum     = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
  assign sh_shift = (sh_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  // Carry into the top bit recovered from its sum bit and operand bits
  assign c_into_msb = dsum[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];

  always_comb begin
    opa_d       = opa_q;
    opb_d       = opb_q;
    sh_d        = sh_q;
    k_d         = k_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub ? ~carry_in : carry_in;
      k_d     = '0;
    end else if (state_q == RUN) begin
      opa_d   = opa_q >> DIGIT;
      opb_d   = opb_q >> DIGIT;
      carry_d = dsum[DIGIT];
      sh_d    = sh_shift;
      k_d     = k_q + KW'(1);
      if (last) begin
        result_d    = sh_shift;
        carry_out_d = dsum[DIGIT];
        overflow_d  = c_into_msb ^ dsum[DIGIT];
        zero_d      = (sh_shift == '0);
      end
    end
  end

  // Working operands need no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    sh_q    <= sh_d;
    k_q     <= k_d;
    carry_q <= carry_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4) instance,
// driven from a table of hand-computed vectors plus directed handshake/reset sequences.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start4;
  logic [7:0] a, b;
  logic       carry_in, sub;

  logic       busy1, done1, co1, ov1, z1;
  logic [7:0] res1;
  logic       busy4, done4, co4, ov4, z4;
  logic [7:0] res4;

  bit         sel;
  logic       cur_busy, cur_done, cur_co, cur_ov, cur_z;
  logic [7:0] cur_res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .busy(busy1), .done(done1),
    .result(res1), .carry_out(co1), .overflow(ov1), .zero(z1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .busy(busy4), .done(done4),
    .result(res4), .carry_out(co4), .overflow(ov4), .zero(z4)
  );

  always_comb begin
    cur_busy = sel ? busy4 : busy1;
    cur_done = sel ? done4 : done1;
    cur_res  = sel ? res4  : res1;
    cur_co   = sel ? co4   : co1;
    cur_ov   = sel ? ov4   : ov1;
    cur_z    = sel ? z4    : z1;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present operands at E0 with start; start is dropped right after E0
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub);
    a = ia; b = ib; carry_in = icin; sub = isub;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Edges counted from the call until done is seen; -1 if it never comes
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (cur_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] r,
                               input logic c, input logic o, input logic zz);
    check({tag, " result"},    cur_res, r);
    check({tag, " carry_out"}, cur_co,  c);
    check({tag, " overflow"},  cur_ov,  o);
    check({tag, " zero"},      cur_z,   zz);
  endtask

  initial begin
    int n;
    string tag;

    //            a      b      cin   sub   result co    ov    zero
    vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #1;
      check($sformatf("reset_busy_d%0d", d), cur_busy, 0);
      check($sformatf("reset_done_d%0d", d), cur_done, 0);
      check_outputs($sformatf("reset_d%0d", d), 8'h00, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors on both instances; latency N = 8 and N = 2
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      for (int i = 0; i < 10; i++) begin
        tag = $sformatf("vec%0d_d%0d", i, d);
        start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
        check({tag, " busy_after_start"}, cur_busy, 1);
        check({tag, " done_after_start"}, cur_done, 0);
        wait_done(n);
        check({tag, " latency"}, n, (d == 1) ? 2 : 8);
        check({tag, " busy_with_done"}, cur_busy, 0);
        check_outputs(tag, vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z);
      end
      @(posedge clk); #1;
      check($sformatf("idle_after_done_d%0d", d), cur_done, 0);
    end

    // Mid-run start and operand changes must be ignored
    sel = 1'b0;
    start_op(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'hFF; sub = 1'b1; carry_in = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(n);
    check("midrun_latency", n, 5);
    check_outputs("midrun", 8'h33, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("result_held_idle", cur_res, 8'h33);

    // Reset in the middle of an operation: no done, outputs cleared
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    check("pre_reset_result_held", cur_res, 8'h33);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", cur_busy, 0);
    check("midreset_done", cur_done, 0);
    check_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cur_done || cur_busy) n++;
    end
    check("no_activity_after_reset", n, 0);

    // Nibble-serial back-to-back: start held in DONE is accepted immediately
    sel = 1'b1;
    start_op(8'h3C, 8'h0F, 1'b1, 1'b0);
    wait_done(n);
    check("d4_latency", n, 2);
    check_outputs("d4_first", 8'h4C, 1'b0, 1'b0, 1'b0);
    a = 8'h01; b = 8'h02; carry_in = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("b2b_busy", cur_busy, 1);
    check("b2b_done", cur_done, 0);
    check("b2b_result_held", cur_res, 8'h4C);
    wait_done(n);
    check("b2b_latency", n, 2);
    check_outputs("b2b_second", 8'h03, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
